// File: rtl/pci_rr_arbiter.sv
// PCI bus arbiter: active-low REQ/GNT, round-robin or fixed priority,
// grant-acceptance timeout, registered owner/status outputs.
module pci_rr_arbiter #(
   parameter int N_MASTERS = 5,
   parameter int RR_MODE   = 1,
   parameter int TIMEOUT   = 16,
   parameter int OWNER_W   = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 frame,
   input  logic                 IRDY,
   input  logic [N_MASTERS-1:0] req,
   output logic [N_MASTERS-1:0] GNT,
   output logic [OWNER_W-1:0]   owner,
   output logic                 owner_valid,
   output logic                 timeout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_BUSY
   } state_t;

   localparam logic [7:0] LP_TMO = 8'(TIMEOUT);

   state_t               r_state, w_state_nxt;
   logic [N_MASTERS-1:0] r_gnt, w_gnt_nxt;
   logic [OWNER_W-1:0]   r_owner, w_owner_nxt;
   logic [OWNER_W-1:0]   r_ptr, w_ptr_nxt;
   logic [OWNER_W-1:0]   w_win;
   logic                 r_ov, w_ov_nxt;
   logic                 r_to, w_to_nxt;
   logic [7:0]           r_timer, w_timer_nxt;
   logic                 w_bus_idle;
   logic                 w_any_req;
   logic                 w_found;
   int                   w_idx;

   assign w_bus_idle = frame & IRDY;
   assign w_any_req  = ~&req;

   // Round-robin search starts just after the last granted master.
   always_comb begin
      w_win   = '0;
      w_found = 1'b0;
      w_idx   = 0;
      if (RR_MODE != 0) begin
         for (int i = 1; i <= N_MASTERS; i++) begin
            w_idx = (int'(r_ptr) + i) % N_MASTERS;
            if (!w_found && !req[OWNER_W'(w_idx)]) begin
               w_found = 1'b1;
               w_win   = OWNER_W'(w_idx);
            end
         end
      end else begin
         for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (!req[OWNER_W'(i)]) begin
               w_win = OWNER_W'(i);
            end
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = '1;
      w_owner_nxt = r_owner;
      w_ptr_nxt   = r_ptr;
      w_ov_nxt    = r_ov;
      w_to_nxt    = 1'b0;
      w_timer_nxt = r_timer;
      unique case (r_state)
         S_IDLE: begin
            if (w_bus_idle && w_any_req) begin
               w_gnt_nxt[w_win] = 1'b0;
               w_owner_nxt      = w_win;
               w_ptr_nxt        = w_win;
               w_ov_nxt         = 1'b1;
               w_timer_nxt      = 8'd1;
               w_state_nxt      = S_GRANT;
            end
         end
         S_GRANT: begin
            if (!frame) begin
               w_state_nxt = S_BUSY;
            end else if (req[r_owner]) begin
               w_ov_nxt    = 1'b0;
               w_state_nxt = S_IDLE;
            end else if (r_timer == LP_TMO) begin
               w_ov_nxt    = 1'b0;
               w_to_nxt    = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_gnt_nxt   = r_gnt;
               w_timer_nxt = r_timer + 8'd1;
            end
         end
         S_BUSY: begin
            if (w_bus_idle) begin
               w_ov_nxt    = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_ov_nxt    = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_gnt   <= '1;
         r_owner <= '0;
         r_ptr   <= OWNER_W'(N_MASTERS - 1);
         r_ov    <= 1'b0;
         r_to    <= 1'b0;
         r_timer <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_gnt   <= w_gnt_nxt;
         r_owner <= w_owner_nxt;
         r_ptr   <= w_ptr_nxt;
         r_ov    <= w_ov_nxt;
         r_to    <= w_to_nxt;
         r_timer <= w_timer_nxt;
      end
   end

   assign GNT         = r_gnt;
   assign owner       = r_owner;
   assign owner_valid = r_ov;
   assign timeout     = r_to;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// Bench for pci_rr_arbiter: three configurations on shared stimulus,
// each compared every cycle against a behavioural model.
module tb_pci_rr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame = 1'b1;
   logic       irdy = 1'b1;
   logic [4:0] req = 5'h1F;

   logic [4:0] d_gnt [3];
   logic [2:0] d_own [3];
   logic       d_ov  [3];
   logic       d_to  [3];

   always #5 clk = ~clk;

   pci_rr_arbiter #(.N_MASTERS(5), .RR_MODE(1), .TIMEOUT(16)) u_rr (
      .clk(clk), .rst(rst), .frame(frame), .IRDY(irdy), .req(req),
      .GNT(d_gnt[0]), .owner(d_own[0]), .owner_valid(d_ov[0]),
      .timeout(d_to[0])
   );

   pci_rr_arbiter #(.N_MASTERS(5), .RR_MODE(0), .TIMEOUT(16)) u_fp (
      .clk(clk), .rst(rst), .frame(frame), .IRDY(irdy), .req(req),
      .GNT(d_gnt[1]), .owner(d_own[1]), .owner_valid(d_ov[1]),
      .timeout(d_to[1])
   );

   pci_rr_arbiter #(.N_MASTERS(5), .RR_MODE(1), .TIMEOUT(4)) u_t4 (
      .clk(clk), .rst(rst), .frame(frame), .IRDY(irdy), .req(req),
      .GNT(d_gnt[2]), .owner(d_own[2]), .owner_valid(d_ov[2]),
      .timeout(d_to[2])
   );

   int n_vec = 0;
   int n_err = 0;

   int m_rr  [3] = '{1, 0, 1};
   int m_tmo [3] = '{16, 16, 4};
   int m_ph  [3];
   int m_own [3];
   int m_tmr [3];
   int m_ptr [3];
   bit m_ov  [3];
   bit m_to  [3];
   bit [4:0] m_gnt [3];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // phases: 0 idle, 1 granted, 2 bus busy
   task automatic model_step();
      for (int m = 0; m < 3; m++) begin
         if (rst) begin
            m_ph[m] = 0; m_gnt[m] = 5'h1F; m_own[m] = 0;
            m_ov[m] = 0; m_to[m] = 0; m_tmr[m] = 0; m_ptr[m] = 4;
         end else begin
            m_to[m] = 0;
            if (m_ph[m] == 0) begin
               m_gnt[m] = 5'h1F;
               if (frame && irdy && req != 5'h1F) begin
                  int w = -1;
                  for (int k = 1; k <= 5; k++) begin
                     int c = m_rr[m] != 0 ? (m_ptr[m] + k) % 5 : k - 1;
                     if (w < 0 && req[c] == 1'b0) w = c;
                  end
                  m_gnt[m] = 5'h1F ^ (5'b1 << w);
                  m_own[m] = w; m_ptr[m] = w;
                  m_ov[m] = 1; m_tmr[m] = 1; m_ph[m] = 1;
               end
            end else if (m_ph[m] == 1) begin
               if (!frame) begin
                  m_ph[m] = 2; m_gnt[m] = 5'h1F;
               end else if (req[m_own[m]]) begin
                  m_ph[m] = 0; m_gnt[m] = 5'h1F; m_ov[m] = 0;
               end else if (m_tmr[m] == m_tmo[m]) begin
                  m_ph[m] = 0; m_gnt[m] = 5'h1F; m_ov[m] = 0; m_to[m] = 1;
               end else begin
                  m_tmr[m]++;
               end
            end else begin
               m_gnt[m] = 5'h1F;
               if (frame && irdy) begin
                  m_ph[m] = 0; m_ov[m] = 0;
               end
            end
         end
      end
   endtask

   task automatic cyc(bit r, bit f, bit i, bit [4:0] q);
      rst = r; frame = f; irdy = i; req = q;
      @(posedge clk);
      model_step();
      @(negedge clk);
      for (int m = 0; m < 3; m++) begin
         chk($sformatf("gnt%0d", m), d_gnt[m], m_gnt[m]);
         chk($sformatf("own%0d", m), d_own[m], m_own[m]);
         chk($sformatf("ov%0d", m), d_ov[m], m_ov[m]);
         chk($sformatf("to%0d", m), d_to[m], m_to[m]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_rr [6] = '{0, 1, 3, 0, 1, 3};
      int lowc;
      int pulc;
      int pf;
      bit [4:0] q;

      cyc(1, 1, 1, 5'b00000);
      cyc(1, 1, 1, 5'b00000);
      chk("rst_gnt", d_gnt[0], 5'h1F);
      chk("rst_ov", d_ov[0], 0);
      chk("rst_to", d_to[0], 0);
      cyc(0, 1, 1, 5'b00000);
      for (int m = 0; m < 3; m++) chk("first_grant", d_gnt[m], 5'b11110);

      cyc(0, 1, 1, 5'b11111);
      cyc(0, 1, 1, 5'b11011);
      chk("single_gnt", d_gnt[0], 5'b11011);
      chk("single_own", d_own[0], 2);
      cyc(0, 0, 0, 5'b11011);
      chk("busy_gnt", d_gnt[0], 5'h1F);
      chk("busy_ov", d_ov[0], 1);
      cyc(0, 1, 1, 5'b11011);
      chk("end_ov", d_ov[0], 0);

      cyc(1, 1, 1, 5'h1F);
      for (int t = 0; t < 6; t++) begin
         cyc(0, 1, 1, 5'b10100);
         chk("rr_order", d_own[0], exp_rr[t]);
         chk("fp_order", d_own[1], 0);
         cyc(0, 0, 0, 5'b10100);
         cyc(0, 1, 0, 5'b10100);
         cyc(0, 1, 1, 5'b10100);
      end

      cyc(1, 1, 1, 5'h1F);
      cyc(0, 1, 1, 5'b11110);
      lowc = 0;
      pulc = 0;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) cyc(0, 1, 1, 5'b11110);
         lowc += int'(!d_gnt[2][0]);
         pulc += int'(d_to[2]);
      end
      chk("tmo_low_cycles", lowc, 4);
      chk("tmo_pulses", pulc, 1);
      cyc(0, 1, 1, 5'b11100);
      chk("tmo_next_own", d_own[2], 1);
      chk("tmo_next_gnt", d_gnt[2], 5'b11101);

      cyc(1, 1, 1, 5'h1F);
      cyc(0, 1, 1, 5'b10111);
      chk("wd_gnt", d_gnt[0], 5'b10111);
      cyc(0, 1, 1, 5'b11111);
      chk("wd_revoke", d_gnt[0], 5'h1F);
      chk("wd_no_to", d_to[0], 0);
      cyc(0, 1, 1, 5'b11101);
      chk("mid_own", d_own[0], 1);
      cyc(0, 0, 0, 5'b11101);
      chk("mid_busy_ov", d_ov[0], 1);
      cyc(1, 0, 0, 5'b11101);
      chk("mid_rst_gnt", d_gnt[0], 5'h1F);
      chk("mid_rst_own", d_own[0], 0);
      chk("mid_rst_ov", d_ov[0], 0);

      for (int s = 0; s < 100; s++) begin
         q = ($urandom_range(0, 4) == 0) ? 5'h1F : 5'($urandom);
         pf = $urandom_range(0, 2);
         for (int c = 0; c < 30; c++) begin
            if ($urandom_range(0, 7) == 0) q = q ^ (5'b1 << $urandom_range(0, 4));
            cyc($urandom_range(0, 199) == 0,
                !(pf != 0 && $urandom_range(0, 3) < pf),
                $urandom_range(0, 3) != 0,
                q);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
